// File: rtl/issue_ctrl_pkg.sv
// issue_ctrl_pkg: pipeline-shared types for the issue stage (stall causes, scoreboard widths).
package issue_ctrl_pkg;
    import width_param::*;
    localparam int SCB_CNT_WIDTH = 2;
    typedef logic [SCB_CNT_WIDTH-1:0]  scb_cnt_t;
    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    localparam scb_cnt_t SCB_MAX = '1;
    typedef enum logic [1:0] {
        STALL_NONE = 2'b00,
        STALL_RAW  = 2'b01,
        STALL_CSR  = 2'b10,
        STALL_FULL = 2'b11
    } stall_cause_e;
    typedef enum logic {IDLE, CSR_WAIT} csr_state_e;
endpackage

// File: rtl/width_param.sv
// width_param: shared datapath and register-address widths.
package width_param;
    localparam int REG_WIDTH      = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;
endpackage

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: saturating pending-write counters for r1..r31; r0 always reads zero.
module issue_scoreboard
    import width_param::*;
    import issue_ctrl_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_clear,
    input  logic      i_inc,
    input  reg_addr_t i_inc_addr,
    input  logic      i_dec,
    input  reg_addr_t i_dec_addr,
    input  reg_addr_t i_rs1_addr,
    input  reg_addr_t i_rs2_addr,
    input  reg_addr_t i_rw_addr,
    output scb_cnt_t  o_rs1_cnt,
    output scb_cnt_t  o_rs2_cnt,
    output scb_cnt_t  o_rw_cnt
);
    scb_cnt_t [NUM_REGS-1:0] w_cnt;
    assign w_cnt[0] = '0;
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        scb_cnt_t r_cnt;
        logic     w_inc;
        logic     w_dec;
        assign w_inc = i_inc && i_inc_addr == reg_addr_t'(r);
        assign w_dec = i_dec && i_dec_addr == reg_addr_t'(r);
        // Simultaneous inc and dec on one register cancel out.
        always_ff @(posedge i_clk)
            if (i_rst || i_clear) r_cnt <= '0;
            else if (w_inc && !w_dec && r_cnt != SCB_MAX) r_cnt <= r_cnt + 1'b1;
            else if (w_dec && !w_inc && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        assign w_cnt[r] = r_cnt;
    end
    assign o_rs1_cnt = w_cnt[i_rs1_addr];
    assign o_rs2_cnt = w_cnt[i_rs2_addr];
    assign o_rw_cnt  = w_cnt[i_rw_addr];
endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: in-order issue gating with scoreboard RAW/full hazards and CSR serialization.
// ISSUE_FORWARD_EN selects load-shadow RAW detection (one load-use bubble) instead of count-based RAW.
module issue_ctrl
    import width_param::*;
    import issue_ctrl_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_id_valid,
    output logic                      o_id_ready,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs2,
    input  logic                      i_id_rs1_en,
    input  logic                      i_id_rs2_en,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rw_addr,
    input  logic                      i_id_rw_en,
    input  logic                      i_id_is_load,
    input  logic                      i_id_csr_wen,
    output logic                      o_issue_valid,
    input  logic                      i_ex_ready,
    input  logic                      i_wb_valid,
    input  logic                      i_wb_rw_en,
    input  logic [REG_ADDR_WIDTH-1:0] i_wb_rw_addr,
    input  logic                      i_csr_commit,
    input  logic                      i_flush,
    output logic [1:0]                o_stall_cause,
    output logic [15:0]               o_stall_cycles
);
    scb_cnt_t     w_rs1_cnt, w_rs2_cnt, w_rw_cnt;
    csr_state_e   r_state;
    logic [15:0]  r_stall_cycles;
    logic         w_req, w_full, w_csr, w_raw, w_hazard, w_fire;
    stall_cause_e w_cause;

    issue_scoreboard u_scb (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (i_flush),
        .i_inc      (w_fire && i_id_rw_en),
        .i_inc_addr (i_id_rw_addr),
        .i_dec      (i_wb_valid && i_wb_rw_en),
        .i_dec_addr (i_wb_rw_addr),
        .i_rs1_addr (i_id_rs1),
        .i_rs2_addr (i_id_rs2),
        .i_rw_addr  (i_id_rw_addr),
        .o_rs1_cnt  (w_rs1_cnt),
        .o_rs2_cnt  (w_rs2_cnt),
        .o_rw_cnt   (w_rw_cnt)
    );

`ifdef ISSUE_FORWARD_EN
    logic      r_sh_valid;
    reg_addr_t r_sh_addr;
    logic      w_unused_cnt;
    assign w_unused_cnt = ^{w_rs1_cnt, w_rs2_cnt};
    assign w_raw = r_sh_valid && r_sh_addr != '0 &&
                   ((i_id_rs1_en && i_id_rs1 == r_sh_addr) || (i_id_rs2_en && i_id_rs2 == r_sh_addr));
    // Shadow lives exactly one EX-advancing cycle: the load-use bubble.
    always_ff @(posedge i_clk)
        if (i_rst || i_flush) r_sh_valid <= 1'b0;
        else if (w_fire && i_id_is_load && i_id_rw_en) begin
            r_sh_valid <= 1'b1;
            r_sh_addr  <= i_id_rw_addr;
        end else if (i_ex_ready) r_sh_valid <= 1'b0;
`else
    logic w_unused_load;
    assign w_unused_load = i_id_is_load;
    assign w_raw = (i_id_rs1_en && w_rs1_cnt != '0) || (i_id_rs2_en && w_rs2_cnt != '0);
`endif

    assign w_req    = i_id_valid && i_ex_ready;
    assign w_full   = i_id_rw_en && w_rw_cnt == SCB_MAX;
    assign w_csr    = r_state == CSR_WAIT;
    assign w_hazard = w_full || w_csr || w_raw;
    assign w_fire   = w_req && !w_hazard && !i_flush;
    assign w_cause  = !w_req ? STALL_NONE : w_full ? STALL_FULL : w_csr ? STALL_CSR :
                      w_raw ? STALL_RAW : STALL_NONE;

    assign o_id_ready     = w_fire;
    assign o_issue_valid  = w_fire;
    assign o_stall_cause  = w_cause;
    assign o_stall_cycles = r_stall_cycles;

    always_ff @(posedge i_clk)
        if (i_rst) r_state <= IDLE;
        else if (i_flush) r_state <= IDLE;
        else if (r_state == IDLE && w_fire && i_id_csr_wen) r_state <= CSR_WAIT;
        else if (r_state == CSR_WAIT && i_csr_commit) r_state <= IDLE;

    always_ff @(posedge i_clk)
        if (i_rst) r_stall_cycles <= '0;
        else if (w_req && w_hazard && r_stall_cycles != 16'hFFFF) r_stall_cycles <= r_stall_cycles + 16'd1;
endmodule
